canvas_glyph_packer: RTL and testbench

//  Consumer of the 32x32 1-bit drawing canvas (small_canva, spo read port). On end of editing,

---
 rtl/glyph_pkg.sv | 21 ++
 rtl/glyph_row_accum.sv | 46 ++++
 rtl/canvas_glyph_packer.sv | 167 ++++++++++++++++
 tb/tb_canvas_glyph_packer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/glyph_pkg.sv
// Shared constants and FSM state type for the canvas-to-glyph packer.
//   CANVAS_LOG2 : canvas side is 2**CANVAS_LOG2 pixels
//   GLYPH_LOG2  : glyph side is 2**GLYPH_LOG2 blocks (also the row byte width)
//   BLOCK_LOG2  : each glyph bit covers a (2**BLOCK_LOG2)^2 pixel block
package glyph_pkg;

   localparam int unsigned CANVAS_LOG2 = 5;
   localparam int unsigned GLYPH_LOG2  = 3;
   localparam int unsigned BLOCK_LOG2  = CANVAS_LOG2 - GLYPH_LOG2;
   localparam int unsigned GLYPH_N     = 2 ** GLYPH_LOG2;
   localparam int unsigned ROW_W       = GLYPH_N;
   localparam int unsigned PIX_W       = 2 * CANVAS_LOG2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      EMIT = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/glyph_row_accum.sv
// 8x8 glyph register file with bit-set, clear, indexed row read and all-zero flag.
//   clk, rst    : clock, synchronous active-high reset (clears all rows)
//   clear_i     : zero every row (takes priority over set_i)
//   set_i       : set bit (7-gx_i) of row gy_i
//   gx_i, gy_i  : glyph column / row of the bit to set
//   rd_idx_i    : row selected onto rd_row_c
//   rd_row_c    : combinational read of row rd_idx_i
//   all_zero_c  : combinational, high when every row is zero
module glyph_row_accum
   import glyph_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear_i,
   input  logic                  set_i,
   input  logic [GLYPH_LOG2-1:0] gx_i,
   input  logic [GLYPH_LOG2-1:0] gy_i,
   input  logic [GLYPH_LOG2-1:0] rd_idx_i,
   output logic [ROW_W-1:0]      rd_row_c,
   output logic                  all_zero_c
);

   logic [GLYPH_N-1:0][ROW_W-1:0] rows_q, rows_d;

   // Next row state; column gx maps to bit (GLYPH_N-1-gx), which is ~gx
   always_comb begin
      rows_d = rows_q;
      if (clear_i) begin
         rows_d = '0;
      end else if (set_i) begin
         rows_d[gy_i][~gx_i] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rows_q <= '0;
      end else begin
         rows_q <= rows_d;
      end
   end

   assign rd_row_c   = rows_q[rd_idx_i];
   assign all_zero_c = (rows_q == '0);

endmodule

// File: rtl/canvas_glyph_packer.sv
// Scans the 32x32 1-bit canvas, OR-reduces each 4x4 block into an 8x8 glyph and
// writes the glyph as 8 handshaked row bytes to the word_display write port.
//   clk, rst     : clock, synchronous active-high reset
//   start        : one-cycle pulse, accepted only in IDLE; latches base_addr
//   base_addr    : destination address of glyph row 0
//   canvas_addr  : {y, x} pixel address into the canvas read port
//   canvas_data  : combinational canvas read data for canvas_addr
//   canvas_stall : canvas port owned by the writer this cycle; scan holds
//   wr_addr/data : row write address (base + r, wrapping) and row byte (bit 7 = gx 0)
//   wr_valid     : row offered; wr_ready accepts it at the clock edge
//   busy         : high during SCAN and EMIT
//   done         : one-cycle pulse after the last row is accepted
//   blank        : glyph was all zero; valid with done, held until next start
module canvas_glyph_packer
   import glyph_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic [PIX_W-1:0]  canvas_addr,
   input  logic              canvas_data,
   input  logic              canvas_stall,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ROW_W-1:0]  wr_data,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic              busy,
   output logic              done,
   output logic              blank
);

   state_e                state_q, state_d;
   logic [PIX_W-1:0]      p_q, p_d;
   logic [GLYPH_LOG2-1:0] r_q, r_d;
   logic [ADDR_W-1:0]     base_q, base_d;
   logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
   logic [ROW_W-1:0]      wr_data_q, wr_data_d;
   logic                  wr_valid_q, wr_valid_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  blank_q, blank_d;

   logic                  acc_clear, acc_set;
   logic [GLYPH_LOG2-1:0] rd_idx_c;
   logic [ROW_W-1:0]      rd_row_c;
   logic                  all_zero_c;

   // Block coordinates are the high bits of x = p[4:0] and y = p[9:5]
   glyph_row_accum u_accum (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (acc_clear),
      .set_i      (acc_set),
      .gx_i       (p_q[CANVAS_LOG2-1 -: GLYPH_LOG2]),
      .gy_i       (p_q[PIX_W-1 -: GLYPH_LOG2]),
      .rd_idx_i   (rd_idx_c),
      .rd_row_c   (rd_row_c),
      .all_zero_c (all_zero_c)
   );

   // Next-state and output logic
   always_comb begin
      state_d    = state_q;
      p_d        = p_q;
      r_d        = r_q;
      base_d     = base_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      wr_valid_d = wr_valid_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      blank_d    = blank_q;
      acc_clear  = 1'b0;
      acc_set    = 1'b0;
      // Preload the row that follows the one being offered
      rd_idx_c   = r_q + GLYPH_LOG2'(1);

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = SCAN;
               base_d    = base_addr;
               p_d       = '0;
               acc_clear = 1'b1;
               busy_d    = 1'b1;
               blank_d   = 1'b0;
            end
         end
         SCAN: begin
            if (!canvas_stall) begin
               acc_set = canvas_data;
               if (&p_q) begin
                  // Last pixel only touches the bottom row, so row 0 is final here
                  state_d    = EMIT;
                  r_d        = '0;
                  rd_idx_c   = '0;
                  wr_valid_d = 1'b1;
                  wr_addr_d  = base_q;
                  wr_data_d  = rd_row_c;
               end else begin
                  p_d = p_q + PIX_W'(1);
               end
            end
         end
         EMIT: begin
            if (wr_valid_q && wr_ready) begin
               if (&r_q) begin
                  state_d    = DONE;
                  wr_valid_d = 1'b0;
                  busy_d     = 1'b0;
                  done_d     = 1'b1;
                  blank_d    = all_zero_c;
               end else begin
                  r_d       = r_q + GLYPH_LOG2'(1);
                  wr_addr_d = wr_addr_q + ADDR_W'(1);
                  wr_data_d = rd_row_c;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         p_q        <= '0;
         r_q        <= '0;
         base_q     <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         blank_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         p_q        <= p_d;
         r_q        <= r_d;
         base_q     <= base_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         wr_valid_q <= wr_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         blank_q    <= blank_d;
      end
   end

   assign canvas_addr = p_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign wr_valid    = wr_valid_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign blank       = blank_q;

endmodule

// File: tb/tb_canvas_glyph_packer.sv
// Self-checking bench for canvas_glyph_packer: table of glyph runs plus reset corner cases.
module tb_canvas_glyph_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [9:0]  base_addr;
   logic [9:0]  canvas_addr;
   logic        canvas_data;
   logic        canvas_stall;
   logic [9:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        wr_valid;
   logic        wr_ready;
   logic        busy;
   logic        done;
   logic        blank;

   logic [1023:0] canvas_mem;

   int n_cmp = 0;
   int n_bad = 0;

   always #20 clk = ~clk;

   // Canvas model; during a stall it returns 1 so any leak into the glyph shows up
   assign canvas_data = canvas_stall ? 1'b1 : canvas_mem[canvas_addr];

   canvas_glyph_packer #(.ADDR_W(10)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .base_addr    (base_addr),
      .canvas_addr  (canvas_addr),
      .canvas_data  (canvas_data),
      .canvas_stall (canvas_stall),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .busy         (busy),
      .done         (done),
      .blank        (blank)
   );

   typedef struct {
      string       name;
      int          pat;        // 0 single px, 1 empty, 2 block+px, 3 diagonal
      logic [9:0]  base;
      int          stall_at;   // first stalled cycle index (0 = none)
      int          stall_len;
      int          hold_row;   // row index on which wr_ready is held low
      int          hold_len;
      bit          restart;    // pulse start during EMIT
      logic [63:0] exp_rows;   // row 0 in bits [63:56]
      bit          exp_blank;
      int          exp_lat;    // cycles from start sample to done visible
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
      end
   endtask

   task automatic load_canvas(input int pat);
      canvas_mem = '0;
      case (pat)
         0: canvas_mem[0] = 1'b1;
         2: begin
            for (int y = 28; y < 32; y++)
               for (int x = 28; x < 32; x++)
                  canvas_mem[y*32 + x] = 1'b1;
            canvas_mem[9*32 + 5] = 1'b1;
         end
         3: for (int i = 0; i < 8; i++) canvas_mem[(4*i)*32 + 4*i] = 1'b1;
         default: ;
      endcase
   endtask

   task automatic check_reset(input string nm);
      chk({nm, ".canvas_addr"}, 64'(canvas_addr), 64'd0);
      chk({nm, ".wr_addr"},     64'(wr_addr),     64'd0);
      chk({nm, ".wr_data"},     64'(wr_data),     64'd0);
      chk({nm, ".wr_valid"},    64'(wr_valid),    64'd0);
      chk({nm, ".busy"},        64'(busy),        64'd0);
      chk({nm, ".done"},        64'(done),        64'd0);
      chk({nm, ".blank"},       64'(blank),       64'd0);
   endtask

   // Drives one glyph run; inputs change and outputs are sampled on the falling edge
   task automatic run_vec(input vec_t v, input int abort_at);
      int         n;
      int         nwr;
      int         hold;
      int         lat;
      bit         seen_done;
      bit         prev_wait;
      bit         restarted;
      logic [9:0] prev_a;
      logic [7:0] prev_d;
      logic [9:0] ea;
      logic [7:0] ed;
      n = 1; nwr = 0; hold = 0; lat = 0;
      seen_done = 0; prev_wait = 0; restarted = 0;
      prev_a = '0; prev_d = '0;
      load_canvas(v.pat);
      @(negedge clk);
      start = 1'b1; base_addr = v.base;
      @(negedge clk);
      start = 1'b0; base_addr = ~v.base;
      chk({v.name, ".busy_rise"}, 64'(busy), 64'd1);
      while (!seen_done && n < 3000) begin
         if (abort_at == n) begin
            rst = 1'b1;
            @(negedge clk);
            check_reset({v.name, ".abort"});
            rst = 1'b0; canvas_stall = 1'b0; wr_ready = 1'b1;
            return;
         end
         if (prev_wait) begin
            chk({v.name, ".hold_addr"}, 64'(wr_addr), 64'(prev_a));
            chk({v.name, ".hold_data"}, 64'(wr_data), 64'(prev_d));
         end
         if (done) begin
            seen_done = 1;
            lat = n;
            break;
         end
         start = 1'b0;
         canvas_stall = (n >= v.stall_at) && (n < v.stall_at + v.stall_len);
         if (wr_valid) begin
            if (v.restart && !restarted) begin
               start = 1'b1;
               base_addr = 10'h155;
               restarted = 1;
            end
            if (nwr == v.hold_row && hold < v.hold_len) begin
               wr_ready = 1'b0;
               hold++;
            end else begin
               wr_ready = 1'b1;
            end
            if (wr_ready) begin
               ea = v.base + 10'(nwr);
               ed = v.exp_rows[63 - 8*nwr -: 8];
               if (nwr < 8) begin
                  chk($sformatf("%s.row%0d_addr", v.name, nwr), 64'(wr_addr), 64'(ea));
                  chk($sformatf("%s.row%0d_data", v.name, nwr), 64'(wr_data), 64'(ed));
               end
               nwr++;
            end
            prev_wait = !wr_ready;
            prev_a = wr_addr;
            prev_d = wr_data;
         end else begin
            wr_ready = 1'b1;
            prev_wait = 0;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0; canvas_stall = 1'b0; wr_ready = 1'b1;
      chk({v.name, ".done_seen"}, 64'(seen_done), 64'd1);
      chk({v.name, ".latency"},   64'(lat),       64'(v.exp_lat));
      chk({v.name, ".row_count"}, 64'(nwr),       64'd8);
      chk({v.name, ".blank"},     64'(blank),     64'(v.exp_blank));
      chk({v.name, ".busy_done"}, 64'(busy),      64'd0);
      chk({v.name, ".valid_done"},64'(wr_valid),  64'd0);
      @(negedge clk);
      chk({v.name, ".done_pulse"},64'(done),      64'd0);
      repeat (3) @(negedge clk);
      chk({v.name, ".idle_busy"}, 64'(busy),      64'd0);
      chk({v.name, ".blank_held"},64'(blank),     64'(v.exp_blank));
   endtask

   initial begin
      vecs[0] = '{"single_px", 0, 10'h100, 0,   0,  -1, 0, 1'b0,
                  64'h8000_0000_0000_0000, 1'b0, 1033};
      vecs[1] = '{"empty",     1, 10'h3FC, 0,   0,  -1, 0, 1'b0,
                  64'h0000_0000_0000_0000, 1'b1, 1033};
      vecs[2] = '{"block_px",  2, 10'h020, 0,   0,  -1, 0, 1'b0,
                  64'h0000_4000_0000_0001, 1'b0, 1033};
      vecs[3] = '{"stall37",   2, 10'h020, 200, 37, -1, 0, 1'b0,
                  64'h0000_4000_0000_0001, 1'b0, 1070};
      vecs[4] = '{"ready_hold",3, 10'h2A0, 0,   0,  4,  3, 1'b1,
                  64'h8040_2010_0804_0201, 1'b0, 1036};
      vecs[5] = '{"post_abort",3, 10'h011, 0,   0,  -1, 0, 1'b0,
                  64'h8040_2010_0804_0201, 1'b0, 1033};

      rst = 1'b1; start = 1'b0; base_addr = '0;
      canvas_stall = 1'b0; wr_ready = 1'b1; canvas_mem = '0;
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 5; i++) run_vec(vecs[i], 0);

      // Abort at p=500, then a clean full run must produce the exact glyph
      run_vec(vecs[5], 501);
      @(negedge clk);
      run_vec(vecs[5], 0);

      // Reset wins over a coincident start
      @(negedge clk);
      rst = 1'b1; start = 1'b1; base_addr = 10'h0F0;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("rst_vs_start.busy", 64'(busy), 64'd0);
      chk("rst_vs_start.canvas_addr", 64'(canvas_addr), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
